// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package imem_pkg;

  localparam int ADDR_W     = 10;
  localparam int IMEM_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid is combinational on the 4th byte.
// Zero latency; it only advances on byte_vld, so upstream stalls simply hold its state.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_valid,
  output logic [31:0] word_dat
);

  logic [1:0]  idx;
  logic [23:0] lanes;

  // The first three bytes shift in from the top, so on the fourth they sit in bits [23:0].
  assign word_valid = byte_vld && (idx == 2'd3);
  assign word_dat   = {byte_dat, lanes};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= 2'd0;
      lanes <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      lanes <= 24'd0;
    end else if (byte_vld) begin
      idx   <= idx + 2'd1;
      lanes <= {byte_dat, lanes[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian image into IMEM; mem_we 1 cycle after each word's 4th byte.
// Idle rx_valid stalls the FSM in place; IMEM_LOADER_CHECKSUM_EN appends an XOR check byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W     = imem_pkg::ADDR_W,
  parameter int unsigned BASE_WADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned       WORDS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = ST_CHK;
`else
  localparam state_t END_ST = ST_DONE;
`endif

  state_t          state;
  logic [15:0]     len;
  logic [15:0]     len_full;
  logic [ADDR_W:0] wl_inc;
  logic            rx_hs;
  logic            byte_vld;
  logic            pack_clear;
  logic            word_valid;
  logic [31:0]     word_dat;

  assign rx_ready   = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CHK);
  assign rx_hs      = rx_valid && rx_ready;
  assign byte_vld   = rx_hs && (state == ST_DATA);
  assign busy       = (state != ST_IDLE);
  assign core_stall = busy;
  assign pack_clear = (state == ST_IDLE) && start;
  assign len_full   = {rx_data, len[7:0]};
  assign wl_inc     = words_loaded + (ADDR_W+1)'(1);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_vld   (byte_vld),
    .byte_dat   (rx_data),
    .word_valid (word_valid),
    .word_dat   (word_dat)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_acc <= 8'd0;
    end else if (pack_clear) begin
      chk_acc <= 8'd0;
    end else if (byte_vld) begin
      chk_acc <= chk_acc ^ rx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      len          <= 16'd0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= 32'd0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        ST_LEN_LO: begin
          if (rx_hs) begin
            len[7:0] <= rx_data;
            state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_hs) begin
            len[15:8] <= rx_data;
            if (len_full == 16'd0) begin
              state <= END_ST;
            end else if (32'(len_full) > WORDS) begin
              state <= ST_ERR;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            mem_we       <= 1'b1;
            mem_waddr    <= BASE_A + words_loaded[ADDR_W-1:0];
            mem_wdata    <= word_dat;
            words_loaded <= wl_inc;
            if (32'(wl_inc) == 32'(len)) begin
              state <= END_ST;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          // The final word was already written on the way in; only the status depends on this byte.
          if (rx_hs) begin
            state <= (rx_data == chk_acc) ? ST_DONE : ST_ERR;
          end
        end
`endif
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          error <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images checked against a byte-stream reference model.
module tb_imem_loader;

  localparam int AW = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          start    = 1'b0;
  logic [7:0]    rx_data  = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_stall;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_W(AW), .BASE_WADDR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .core_stall   (core_stall),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [AW-1:0] wq_a[$];
  logic [31:0]   wq_d[$];
  int            wq_c[$];
  logic [7:0]    pay[$];
  logic [7:0]    stim[$];
  int            hs_cyc[$];
  int            tail;
  bit            tail_to;
  bit            gap_bad;
  int            n_rej;
  bit            start_noise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wq_a.push_back(mem_waddr);
      wq_d.push_back(mem_wdata);
      wq_c.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Reference: word i of the image is the weighted sum of payload bytes 4i..4i+3.
  function automatic logic [31:0] model_word(input int i);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < 4; k++) w = w + 32'(pay[4*i+k]) * (32'd1 << (8*k));
    return w;
  endfunction

  function automatic logic [7:0] model_xor();
    logic [7:0] x = 8'd0;
    foreach (pay[i]) x = x ^ pay[i];
    return x;
  endfunction

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  // chk_mode: 0 correct checksum, 1 corrupted checksum, 2 no checksum byte appended
  task automatic make_stim(input int len, input int chk_mode);
    logic [7:0] cb;
    cb = model_xor() ^ ((chk_mode == 1) ? 8'($urandom_range(1, 255)) : 8'h00);
    stim.delete();
    stim.push_back(8'(len));
    stim.push_back(8'(len >> 8));
    foreach (pay[i]) stim.push_back(pay[i]);
    if (CHK_EN && chk_mode != 2) stim.push_back(cb);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (!busy || !rx_ready) gap_bad = 1'b1;
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    start    = start_noise;
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        at = cyc;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_stream(input int gap, input bit wait_idle);
    bit ok;
    int at;
    wq_a.delete(); wq_d.delete(); wq_c.delete(); hs_cyc.delete();
    gap_bad = 1'b0; n_rej = 0; tail = 0; tail_to = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    foreach (stim[i]) begin
      send_byte(stim[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap, ok, at);
      if (!ok) n_rej++;
      else if (i >= 2 && i < 2 + pay.size() && (i - 2) % 4 == 3) hs_cyc.push_back(at);
    end
    if (wait_idle) begin
      tail_to = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!busy) begin
          tail_to = 1'b0;
          break;
        end
        tail++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    n_chk++; if ({busy, core_stall, done, error, rx_ready, mem_we} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {busy, core_stall, done, error, rx_ready, mem_we});
    else n_pass++;
    n_chk++; if (words_loaded !== '0 || mem_waddr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_data: got wl=%0d a=%h d=%h want 0", words_loaded, mem_waddr, mem_wdata);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || rx_ready !== 1'b0)
      $display("FAIL reset_release_idle: got busy=%b rdy=%b want 0 0", busy, rx_ready);
    else n_pass++;
  endtask

  task automatic test_basic(input string name, input int gap);
    logic [7:0]  img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    logic [31:0] exp_w [2] = '{32'h00100513, 32'h00500093};
    pay.delete();
    foreach (img[i]) pay.push_back(img[i]);
    make_stim(2, 0);
    run_stream(gap, 1'b1);
    n_chk++; if (wq_a.size() !== 2)
      $display("FAIL %s_wr_count: got %0d want 2", name, wq_a.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < wq_a.size() && i < hs_cyc.size(); i++) begin
      n_chk++; if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_w[i] || wq_c[i] !== hs_cyc[i] + 1)
        $display("FAIL %s_wr%0d: got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d",
                 name, i, wq_a[i], wq_d[i], wq_c[i], AW'(i), exp_w[i], hs_cyc[i] + 1);
      else n_pass++;
    end
    n_chk++; if (words_loaded !== 11'd2 || done !== 1'b1 || error !== 1'b0)
      $display("FAIL %s_status: got wl=%0d done=%b err=%b want 2 1 0", name, words_loaded, done, error);
    else n_pass++;
    n_chk++; if (tail_to || tail !== 1 || busy !== 1'b0 || core_stall !== 1'b0 || rx_ready !== 1'b0)
      $display("FAIL %s_release: got tail=%0d to=%b busy=%b stall=%b rdy=%b want 1 0 0 0 0",
               name, tail, tail_to, busy, core_stall, rx_ready);
    else n_pass++;
    n_chk++; if (gap_bad !== 1'b0)
      $display("FAIL %s_busy_in_gaps: got gap_bad=%b want 0", name, gap_bad);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    pay.delete();
    make_stim(0, 0);
    run_stream(0, 1'b1);
    n_chk++; if (wq_a.size() !== 0 || n_rej !== 0)
      $display("FAIL len0_writes: got writes=%0d rej=%0d want 0 0", wq_a.size(), n_rej);
    else n_pass++;
    n_chk++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== '0 || tail !== 1)
      $display("FAIL len0_status: got done=%b err=%b wl=%0d tail=%0d want 1 0 0 1",
               done, error, words_loaded, tail);
    else n_pass++;
  endtask

  task automatic test_len_overflow();
    rand_pay(4);
    make_stim(1025, 2);
    run_stream(0, 1'b1);
    n_chk++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL ovf_status: got err=%b done=%b busy=%b want 1 0 0", error, done, busy);
    else n_pass++;
    n_chk++; if (wq_a.size() !== 0 || n_rej !== 4 || words_loaded !== '0)
      $display("FAIL ovf_writes: got writes=%0d rej=%0d wl=%0d want 0 4 0", wq_a.size(), n_rej, words_loaded);
    else n_pass++;
  endtask

  task automatic test_len_max();
    int bad = 0;
    rand_pay(4 * 1024);
    make_stim(1024, 0);
    run_stream(0, 1'b1);
    for (int i = 0; i < wq_a.size() && i < 1024; i++)
      if (wq_a[i] !== AW'(i) || wq_d[i] !== model_word(i)) bad++;
    n_chk++; if (wq_a.size() !== 1024 || bad !== 0)
      $display("FAIL lenmax_writes: got writes=%0d bad=%0d want 1024 0", wq_a.size(), bad);
    else n_pass++;
    n_chk++; if (words_loaded !== 11'd1024 || done !== 1'b1 || error !== 1'b0)
      $display("FAIL lenmax_status: got wl=%0d done=%b err=%b want 1024 1 0", words_loaded, done, error);
    else n_pass++;
  endtask

  task automatic test_reset_midload();
    rand_pay(8);
    make_stim(2, 2);
    stim = stim[0:6];
    run_stream(0, 1'b0);
    n_chk++; if (wq_a.size() !== 1 || busy !== 1'b1)
      $display("FAIL midload_pre: got writes=%0d busy=%b want 1 1", wq_a.size(), busy);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({busy, core_stall, done, error, rx_ready, mem_we} !== 6'b0 ||
                 words_loaded !== '0 || mem_waddr !== '0 || mem_wdata !== '0)
      $display("FAIL midload_async_clear: got flags=%b wl=%0d a=%h d=%h want all 0",
               {busy, core_stall, done, error, rx_ready, mem_we}, words_loaded, mem_waddr, mem_wdata);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    rand_pay(4);
    make_stim(1, 0);
    run_stream(0, 1'b1);
    n_chk++; if (wq_a.size() !== 1 || wq_a[0] !== '0 || wq_d[0] !== model_word(0) || done !== 1'b1)
      $display("FAIL midload_reload: got writes=%0d a=%h d=%h done=%b want 1 000 %h 1",
               wq_a.size(), (wq_a.size() > 0) ? wq_a[0] : '1, (wq_d.size() > 0) ? wq_d[0] : '1,
               done, model_word(0));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int len  = int'($urandom_range(1, 16));
      int mode = int'($urandom_range(0, 1));
      bit exp_err = CHK_EN && (mode == 1);
      rand_pay(4 * len);
      make_stim(len, mode);
      start_noise = 1'b1;
      run_stream(-1, 1'b1);
      start_noise = 1'b0;
      n_chk++; if (wq_a.size() !== len)
        $display("FAIL rand%0d_wr_count: got %0d want %0d", it, wq_a.size(), len);
      else n_pass++;
      for (int i = 0; i < len && i < wq_a.size() && i < hs_cyc.size(); i++) begin
        n_chk++; if (wq_a[i] !== AW'(i) || wq_d[i] !== model_word(i) || wq_c[i] !== hs_cyc[i] + 1)
          $display("FAIL rand%0d_wr%0d: got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d",
                   it, i, wq_a[i], wq_d[i], wq_c[i], AW'(i), model_word(i), hs_cyc[i] + 1);
        else n_pass++;
      end
      n_chk++; if (words_loaded !== 11'(len) || done !== !exp_err || error !== exp_err || tail !== 1)
        $display("FAIL rand%0d_status: got wl=%0d done=%b err=%b tail=%0d want %0d %b %b 1",
                 it, words_loaded, done, error, tail, len, !exp_err, exp_err);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    rand_pay(12);
    make_stim(3, 0);
    run_stream(0, 1'b1);
    rand_pay(8);
    make_stim(2, 0);
    run_stream(0, 1'b1);
    n_chk++; if (wq_a.size() !== 2 || wq_a[0] !== '0 || wq_a[1] !== AW'(1) ||
                 wq_d[0] !== model_word(0) || wq_d[1] !== model_word(1))
      $display("FAIL b2b_writes: got n=%0d want 2 writes at 000/001 of %h %h",
               wq_a.size(), model_word(0), model_word(1));
    else n_pass++;
    n_chk++; if (wq_c.size() !== 2 || wq_c[1] - wq_c[0] !== 4 || words_loaded !== 11'd2)
      $display("FAIL b2b_spacing: got n=%0d wl=%0d want spacing 4 wl 2", wq_c.size(), words_loaded);
    else n_pass++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      pay.delete();
      pay.push_back(8'h13); pay.push_back(8'h00); pay.push_back(8'h00); pay.push_back(8'h00);
      make_stim(1, 2);
      stim.push_back((pass == 0) ? 8'h12 : 8'h13);
      run_stream(0, 1'b1);
      n_chk++; if (wq_a.size() !== 1 || wq_d[0] !== 32'h00000013)
        $display("FAIL chk%0d_write: got n=%0d want 1 write of 00000013", pass, wq_a.size());
      else n_pass++;
      n_chk++; if (error !== (pass == 0) || done !== (pass == 1))
        $display("FAIL chk%0d_status: got err=%b done=%b want %b %b", pass, error, done, pass == 0, pass == 1);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic("basic", 0);
    test_basic("gaps", 3);
    test_len_zero();
    test_len_overflow();
    test_len_max();
    test_reset_midload();
    test_random();
    test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
